// File: rtl/vga_console_writer_if.sv
// Signal bundle between the console writer and its environment: the input
// byte stream, the Wishbone-style bus to the text-mode VGA device, and the
// cursor/status outputs.
//   master : the console writer (consumes bytes, drives the bus)
//   slave  : the byte source plus the VGA device
interface vga_console_writer_if;
  logic        io_in_valid;
  logic [7:0]  io_in_bits;
  logic        io_in_ready;
  logic [7:0]  io_attr;
  logic [31:0] io_bus_addr;
  logic [31:0] io_bus_dat2;
  logic [31:0] io_bus_dat4;
  logic        io_bus_sel;
  logic        io_bus_we;
  logic        io_bus_ack;
  logic [6:0]  io_cursor_x;
  logic [4:0]  io_cursor_y;
  logic        io_busy;

  modport master (
    input  io_in_valid, io_in_bits, io_attr, io_bus_dat4, io_bus_ack,
    output io_in_ready, io_bus_addr, io_bus_dat2, io_bus_sel, io_bus_we,
           io_cursor_x, io_cursor_y, io_busy
  );

  modport slave (
    output io_in_valid, io_in_bits, io_attr, io_bus_dat4, io_bus_ack,
    input  io_in_ready, io_bus_addr, io_bus_dat2, io_bus_sel, io_bus_we,
           io_cursor_x, io_cursor_y, io_busy
  );
endinterface

// File: rtl/vga_console_writer.sv
// Character-stream front end for a text-mode VGA device (COLS x ROWS cells,
// 16-bit cell = {attr, char}). Accepts ASCII bytes, keeps a cursor, handles
// control characters and performs scroll / clear-screen through bus
// read/write sequences. It is the only master on the VGA bus.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   io     vga_console_writer_if.master: byte stream (valid/ready/bits/attr),
//          bus (addr/dat2/dat4/sel/we/ack), cursor x/y, busy
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a byte (ready high)
// PUTC      | one cell write (printable char or backspace blank)
// SCR_RD    | scroll copy: read cell idx+COLS
// SCR_WR    | scroll copy: write captured cell to idx
// FILL      | write {attr,0x20} to idx .. fill_hi (scroll tail or FF)
// BUS_GAP   | mandatory bus-idle cycle, then go to ret state
module vga_console_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_console_writer_if.master   io
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUTC, S_SCR_RD, S_SCR_WR, S_FILL, S_BUS_GAP
  } state_e;

  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [7:0]  COLS_X    = 8'(COLS);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] COPY_N    = 12'(COLS * (ROWS - 1));
  localparam logic [11:0] COPY_LAST = 12'(COLS * (ROWS - 1) - 1);
  localparam logic [11:0] LAST_IDX  = 12'(COLS * ROWS - 1);
  localparam bit          HAS_COPY  = (ROWS > 1);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic [6:0]  pend_x_q, pend_x_d;
  logic [4:0]  pend_y_q, pend_y_d;
  logic        scr_q, scr_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  char_q, char_d;
  logic [11:0] idx_q, idx_d;
  logic [11:0] fill_hi_q, fill_hi_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        seen_low_q, seen_low_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] dat_q, dat_d;

  logic        bus_done;
  logic [11:0] lin;
  logic [7:0]  x_inc;
  logic [7:0]  x_tab;
  logic        newline;
  logic        unused_dat4_hi;

  // A completion needs ack to have been seen low first, so a stale ack left
  // over from a previous transaction cannot finish the current one.
  assign bus_done       = sel_q && io.io_bus_ack && seen_low_q;
  assign lin            = 12'(cur_y_q) * COLS_W + 12'(cur_x_q);
  assign x_inc          = {1'b0, cur_x_q} + 8'd1;
  assign x_tab          = ({1'b0, cur_x_q} | 8'd7) + 8'd1;
  assign unused_dat4_hi = ^io.io_bus_dat4[31:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      scr_q      <= 1'b0;
      attr_q     <= '0;
      char_q     <= '0;
      idx_q      <= '0;
      fill_hi_q  <= '0;
      rd_data_q  <= '0;
      seen_low_q <= 1'b0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      scr_q      <= scr_d;
      attr_q     <= attr_d;
      char_q     <= char_d;
      idx_q      <= idx_d;
      fill_hi_q  <= fill_hi_d;
      rd_data_q  <= rd_data_d;
      seen_low_q <= seen_low_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    pend_x_d  = pend_x_q;
    pend_y_d  = pend_y_q;
    scr_d     = scr_q;
    attr_d    = attr_q;
    char_d    = char_q;
    idx_d     = idx_q;
    fill_hi_d = fill_hi_q;
    rd_data_d = rd_data_q;
    newline   = 1'b0;

    if (!sel_q || bus_done) begin
      seen_low_d = 1'b0;
    end else if (!io.io_bus_ack) begin
      seen_low_d = 1'b1;
    end else begin
      seen_low_d = seen_low_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (io.io_in_valid) begin
          attr_d  = io.io_attr;
          scr_d   = 1'b0;
          state_d = S_BUS_GAP;
          ret_d   = S_IDLE;
          if (io.io_in_bits >= 8'h20 && io.io_in_bits <= 8'h7E) begin
            char_d  = io.io_in_bits;
            idx_d   = lin;
            state_d = S_PUTC;
            if (x_inc == COLS_X) begin
              pend_x_d = '0;
              if (cur_y_q == LAST_ROW) begin
                pend_y_d = cur_y_q;
                scr_d    = 1'b1;
              end else begin
                pend_y_d = cur_y_q + 5'd1;
              end
            end else begin
              pend_x_d = x_inc[6:0];
              pend_y_d = cur_y_q;
            end
          end else begin
            case (io.io_in_bits)
              8'h0A: newline = 1'b1;
              8'h0D: cur_x_d = '0;
              8'h08: begin
                if (cur_x_q != 7'd0) begin
                  pend_x_d = cur_x_q - 7'd1;
                  pend_y_d = cur_y_q;
                  idx_d    = lin - 12'd1;
                  char_d   = 8'h20;
                  state_d  = S_PUTC;
                end
              end
              8'h09: begin
                if (x_tab >= COLS_X) begin
                  newline = 1'b1;
                end else begin
                  cur_x_d = x_tab[6:0];
                end
              end
              8'h0C: begin
                idx_d     = '0;
                fill_hi_d = LAST_IDX;
                char_d    = 8'h20;
                pend_x_d  = '0;
                pend_y_d  = '0;
                state_d   = S_FILL;
              end
              default: ;
            endcase
            if (newline) begin
              if (cur_y_q == LAST_ROW) begin
                // Scroll starts straight from IDLE; cursor lands when the
                // tail fill finishes.
                pend_x_d  = '0;
                pend_y_d  = LAST_ROW;
                char_d    = 8'h20;
                fill_hi_d = LAST_IDX;
                idx_d     = '0;
                state_d   = HAS_COPY ? S_SCR_RD : S_FILL;
              end else begin
                cur_x_d = '0;
                cur_y_d = cur_y_q + 5'd1;
              end
            end
          end
        end
      end
      S_PUTC: begin
        if (bus_done) begin
          state_d = S_BUS_GAP;
          if (scr_q) begin
            scr_d     = 1'b0;
            idx_d     = '0;
            char_d    = 8'h20;
            fill_hi_d = LAST_IDX;
            ret_d     = HAS_COPY ? S_SCR_RD : S_FILL;
          end else begin
            cur_x_d = pend_x_q;
            cur_y_d = pend_y_q;
            ret_d   = S_IDLE;
          end
        end
      end
      S_SCR_RD: begin
        if (bus_done) begin
          rd_data_d = io.io_bus_dat4[15:0];
          state_d   = S_BUS_GAP;
          ret_d     = S_SCR_WR;
        end
      end
      S_SCR_WR: begin
        if (bus_done) begin
          state_d = S_BUS_GAP;
          if (idx_q == COPY_LAST) begin
            idx_d = COPY_N;
            ret_d = S_FILL;
          end else begin
            idx_d = idx_q + 12'd1;
            ret_d = S_SCR_RD;
          end
        end
      end
      S_FILL: begin
        if (bus_done) begin
          state_d = S_BUS_GAP;
          if (idx_q == fill_hi_q) begin
            cur_x_d = pend_x_q;
            cur_y_d = pend_y_q;
            ret_d   = S_IDLE;
          end else begin
            idx_d = idx_q + 12'd1;
            ret_d = S_FILL;
          end
        end
      end
      S_BUS_GAP: state_d = ret_q;
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus registers are loaded from the next state so sel rises on the same
  // edge that enters a transaction state and holds until completion.
  always_comb begin
    sel_d  = 1'b0;
    we_d   = 1'b0;
    addr_d = '0;
    dat_d  = '0;
    if (state_d == S_PUTC || state_d == S_SCR_RD ||
        state_d == S_SCR_WR || state_d == S_FILL) begin
      sel_d  = 1'b1;
      we_d   = (state_d != S_SCR_RD);
      addr_d = (state_d == S_SCR_RD) ? idx_d + COLS_W : idx_d;
      dat_d  = (state_d == S_SCR_WR) ? rd_data_d : {attr_d, char_d};
    end
  end

  assign io.io_in_ready = (state_q == S_IDLE) && reset;
  assign io.io_busy     = (state_q != S_IDLE);
  assign io.io_bus_sel  = sel_q;
  assign io.io_bus_we   = we_q;
  assign io.io_bus_addr = BASE_ADDR | {20'd0, addr_q};
  assign io.io_bus_dat2 = {16'h0, dat_q};
  assign io.io_cursor_x = cur_x_q;
  assign io.io_cursor_y = cur_y_q;

endmodule

// File: tb/tb_vga_console_writer.sv
module tb_vga_console_writer;

  typedef struct {
    bit          we;
    logic [11:0] idx;
    logic [15:0] dat;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_console_writer_if bus_if ();

  vga_console_writer #(.BASE_ADDR(32'h0), .COLS(80), .ROWS(30)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus_if)
  );

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [11:0] last_addr = '0;
  bit ignore_mon = 1'b0;

  txn_t exp_q[$];
  logic [15:0] shadow [0:4095];
  int cx = 0;
  int cy = 0;
  logic [7:0] cur_attr = 8'h07;

  // VGA slave model: ack on the third sel cycle plus `extra` stretch cycles.
  logic [15:0] mem [0:4095] = '{default: 16'h0};
  int cnt = 0;
  int extra = 0;
  bit pl_en = 1'b0;
  logic [11:0] pl_idx = '0;
  logic [15:0] pl_dat = '0;

  always @(posedge clk) begin
    if (bus_if.io_bus_sel) cnt <= cnt + 1;
    else cnt <= 0;
    if (bus_if.io_bus_sel && bus_if.io_bus_ack && bus_if.io_bus_we)
      mem[bus_if.io_bus_addr[11:0]] <= bus_if.io_bus_dat2[15:0];
    else if (pl_en)
      mem[pl_idx] <= pl_dat;
  end

  assign bus_if.io_bus_ack  = bus_if.io_bus_sel && (cnt == 2 + extra);
  assign bus_if.io_bus_dat4 = {16'h0, mem[bus_if.io_bus_addr[11:0]]};

  task automatic check(input bit ok, input string name,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Monitor: snapshot bus outputs when sel rises, require them stable, and
  // compare against the scoreboard on the completion cycle.
  bit in_txn = 1'b0;
  bit stable = 1'b1;
  logic [31:0] s_addr, s_dat;
  logic s_we;
  txn_t t_m;
  bit ok_m;

  always @(negedge clk) begin
    if (!bus_if.io_bus_sel) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn) begin
        in_txn = 1'b1;
        stable = 1'b1;
        s_addr = bus_if.io_bus_addr;
        s_dat  = bus_if.io_bus_dat2;
        s_we   = bus_if.io_bus_we;
      end else if (bus_if.io_bus_addr != s_addr || bus_if.io_bus_dat2 != s_dat ||
                   bus_if.io_bus_we != s_we) begin
        stable = 1'b0;
      end
      if (bus_if.io_bus_ack) begin
        in_txn = 1'b0;
        if (bus_if.io_bus_we) wr_cnt++;
        else rd_cnt++;
        last_addr = bus_if.io_bus_addr[11:0];
        if (!ignore_mon) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_txn got we=%0d addr=0x%0h dat=0x%0h want none",
                     bus_if.io_bus_we, bus_if.io_bus_addr, bus_if.io_bus_dat2);
          end else begin
            t_m = exp_q.pop_front();
            ok_m = stable && (bus_if.io_bus_we == t_m.we) &&
                   (bus_if.io_bus_addr == {20'h0, t_m.idx}) &&
                   (!t_m.we || bus_if.io_bus_dat2 == {16'h0, t_m.dat});
            if (!ok_m) begin
              failures++;
              $display("FAIL txn got we=%0d addr=0x%0h dat=0x%0h stable=%0d want we=%0d addr=0x%0h dat=0x%0h",
                       bus_if.io_bus_we, bus_if.io_bus_addr, bus_if.io_bus_dat2, stable,
                       t_m.we, t_m.idx, t_m.dat);
            end
          end
        end
      end
    end
  end

  task automatic exp_wr(input int idx, input logic [15:0] d);
    txn_t t;
    t.we = 1'b1; t.idx = 12'(idx); t.dat = d;
    exp_q.push_back(t);
    shadow[idx] = d;
  endtask

  task automatic exp_rd(input int idx);
    txn_t t;
    t.we = 1'b0; t.idx = 12'(idx); t.dat = 16'h0;
    exp_q.push_back(t);
  endtask

  task automatic model_newline();
    if (cy == 29) begin
      for (int i = 0; i < 2320; i++) begin
        exp_rd(i + 80);
        exp_wr(i, shadow[i + 80]);
      end
      for (int i = 2320; i < 2400; i++) exp_wr(i, {cur_attr, 8'h20});
    end else begin
      cy++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int t;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_wr(cy * 80 + cx, {cur_attr, b});
      cx++;
      if (cx == 80) begin
        cx = 0;
        model_newline();
      end
    end else begin
      case (b)
        8'h0A: begin cx = 0; model_newline(); end
        8'h0D: cx = 0;
        8'h08: if (cx > 0) begin cx--; exp_wr(cy * 80 + cx, {cur_attr, 8'h20}); end
        8'h09: begin
          t = (cx | 7) + 1;
          if (t >= 80) begin cx = 0; model_newline(); end
          else cx = t;
        end
        8'h0C: begin
          for (int i = 0; i < 2400; i++) exp_wr(i, {cur_attr, 8'h20});
          cx = 0; cy = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus_if.io_in_ready && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40000) check(1'b0, "ready_timeout", 32'(bus_if.io_in_ready), 32'd1);
    bus_if.io_in_valid = 1'b1;
    bus_if.io_in_bits  = b;
    bus_if.io_attr     = cur_attr;
    @(posedge clk);
    #1 bus_if.io_in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int low);
    low = 0;
    forever begin
      @(negedge clk);
      if (bus_if.io_in_ready) break;
      low++;
      if (low >= 40000) begin
        check(1'b0, "idle_timeout", 32'(low), 32'd0);
        break;
      end
    end
  endtask

  task automatic check_cursor(input string name, input int x, input int y);
    check(bus_if.io_cursor_x == 7'(x) && bus_if.io_cursor_y == 5'(y), name,
          {20'h0, bus_if.io_cursor_y, bus_if.io_cursor_x}, {20'h0, 5'(y), 7'(x)});
  endtask

  task automatic send(input logic [7:0] b, output int low);
    model_byte(b);
    drive_byte(b);
    wait_idle(low);
    check_cursor("cursor_model", cx, cy);
    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  int lat;
  int n0, r0, w0;
  bit all_ok;

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = 16'h0;
    bus_if.io_in_valid = 1'b0;
    bus_if.io_in_bits  = 8'h0;
    bus_if.io_attr     = 8'h0;

    repeat (3) @(negedge clk);
    check(bus_if.io_bus_sel == 1'b0, "rst_sel", 32'(bus_if.io_bus_sel), 32'd0);
    check(bus_if.io_in_ready == 1'b0, "rst_ready", 32'(bus_if.io_in_ready), 32'd0);
    check(bus_if.io_bus_addr == 32'h0 && bus_if.io_bus_dat2 == 32'h0 && bus_if.io_bus_we == 1'b0,
          "rst_bus", bus_if.io_bus_addr | bus_if.io_bus_dat2, 32'h0);
    check_cursor("rst_cursor", 0, 0);
    reset = 1'b1;
    @(negedge clk);
    check(bus_if.io_in_ready == 1'b1, "ready_after_rst", 32'(bus_if.io_in_ready), 32'd1);

    // 'A' at (0,0): one write, 3 sel cycles + gap -> ready low 4 samples
    cur_attr = 8'h07;
    send(8'h41, lat);
    check(lat == 4, "ready_latency", 32'(lat), 32'd4);
    check(mem[0] == 16'h0741, "cell_A", 32'(mem[0]), 32'h0741);
    check_cursor("cursor_A", 1, 0);

    send(8'h0A, lat);
    send(8'h0A, lat);
    for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26), lat);
    check_cursor("cursor_79_2", 79, 2);

    send(8'h5A, lat);
    check(last_addr == 12'd239, "wrap_addr", 32'(last_addr), 32'd239);
    check(mem[239] == 16'h075A, "cell_Z", 32'(mem[239]), 32'h075A);
    check_cursor("cursor_wrap", 0, 3);

    send(8'h0A, lat);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), lat);
    cur_attr = 8'h1C;
    send(8'h08, lat);
    check(last_addr == 12'd324, "bs_addr", 32'(last_addr), 32'd324);
    check(mem[324] == 16'h1C20, "bs_cell", 32'(mem[324]), 32'h1C20);
    check_cursor("cursor_bs", 4, 4);

    send(8'h0D, lat);
    n0 = rd_cnt + wr_cnt;
    send(8'h08, lat);
    check(rd_cnt + wr_cnt == n0, "bs_x0_nobus", 32'(rd_cnt + wr_cnt - n0), 32'd0);
    check_cursor("cursor_bs_x0", 0, 4);

    send(8'h01, lat);
    check(lat == 1, "ignored_latency", 32'(lat), 32'd1);
    check(rd_cnt + wr_cnt == n0, "ignored_nobus", 32'(rd_cnt + wr_cnt - n0), 32'd0);

    // scroll from (3,29) with a preloaded cell in row 1
    for (int i = 0; i < 25; i++) send(8'h0A, lat);
    for (int i = 0; i < 3; i++) send(8'h78, lat);
    check_cursor("cursor_3_29", 3, 29);
    @(negedge clk);
    pl_idx = 12'd80; pl_dat = 16'h1E41; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    shadow[80] = 16'h1E41;
    cur_attr = 8'h2F;
    r0 = rd_cnt; w0 = wr_cnt;
    send(8'h0A, lat);
    check(mem[0] == 16'h1E41, "scroll_cell0", 32'(mem[0]), 32'h1E41);
    all_ok = 1'b1;
    for (int i = 2320; i < 2400; i++) if (mem[i] != 16'h2F20) all_ok = 1'b0;
    check(all_ok, "scroll_tail", 32'(all_ok), 32'd1);
    check(rd_cnt - r0 == 2320, "scroll_reads", 32'(rd_cnt - r0), 32'd2320);
    check(wr_cnt - w0 == 2400, "scroll_writes", 32'(wr_cnt - w0), 32'd2400);
    check_cursor("cursor_scroll", 0, 29);
    all_ok = 1'b1;
    for (int i = 0; i < 2400; i++) if (mem[i] != shadow[i]) all_ok = 1'b0;
    check(all_ok, "screen_match", 32'(all_ok), 32'd1);

    n0 = rd_cnt + wr_cnt;
    send(8'h09, lat);
    check_cursor("cursor_tab", 8, 29);
    check(rd_cnt + wr_cnt == n0, "tab_nobus", 32'(rd_cnt + wr_cnt - n0), 32'd0);

    // clear screen with a slow slave
    extra = 5;
    cur_attr = 8'h4E;
    w0 = wr_cnt; r0 = rd_cnt;
    send(8'h0C, lat);
    extra = 0;
    check(wr_cnt - w0 == 2400, "ff_writes", 32'(wr_cnt - w0), 32'd2400);
    check(rd_cnt - r0 == 0, "ff_reads", 32'(rd_cnt - r0), 32'd0);
    check(mem[0] == 16'h4E20 && mem[2399] == 16'h4E20, "ff_cells", 32'(mem[2399]), 32'h4E20);
    check_cursor("cursor_ff", 0, 0);

    for (int i = 0; i < 10; i++) send(8'h09, lat);
    check_cursor("cursor_tab_wrap", 0, 1);

    // reset in the middle of a scroll copy
    for (int i = 0; i < 28; i++) send(8'h0A, lat);
    check_cursor("cursor_pre_rst", 0, 29);
    ignore_mon = 1'b1;
    drive_byte(8'h0A);
    repeat (40) @(negedge clk);
    n0 = 0;
    while (!bus_if.io_bus_sel && n0 < 100) begin
      @(negedge clk);
      n0++;
    end
    check(bus_if.io_bus_sel == 1'b1, "sel_before_rst", 32'(bus_if.io_bus_sel), 32'd1);
    #2 reset = 1'b0;
    #1;
    check(bus_if.io_bus_sel == 1'b0, "rst_async_sel", 32'(bus_if.io_bus_sel), 32'd0);
    check(bus_if.io_in_ready == 1'b0, "rst_async_ready", 32'(bus_if.io_in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check(bus_if.io_in_ready == 1'b1 && bus_if.io_busy == 1'b0, "ready_post_rst",
          32'(bus_if.io_in_ready), 32'd1);
    check_cursor("cursor_post_rst", 0, 0);
    ignore_mon = 1'b0;
    cx = 0; cy = 0;
    cur_attr = 8'h07;
    send(8'h42, lat);
    check_cursor("cursor_B", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_console_writer.md
Name: vga_console_writer

Overview:
- Character-stream front end for the Wishbone text-mode VGA device (80x30 cells, 16-bit cell = {attr[7:0], char[7:0]}, cell index on bus address bits [11:0]).
- Accepts ASCII bytes over a valid/ready stream, for example from UART RX or a CPU mailbox, and acts as the sole bus master of the VGA device.
- Maintains a cursor, interprets control characters, and performs hardware scroll and clear by bus read/write sequences.

Parameters:
- BASE_ADDR, 32'h0: OR'd into every bus address; bits [11:0] must be zero.
- COLS, 80: columns per row.
- ROWS, 30: rows per screen; COLS*ROWS must not exceed 4096.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- io_in_valid  in  1  input byte valid.
- io_in_bits  in  8  ASCII byte.
- io_in_ready  out  1  byte accepted when valid&&ready at a rising edge.
- io_attr  in  8  attribute for written cells, sampled when a byte is accepted.
- io_bus_addr  out  32  BASE_ADDR | cell index.
- io_bus_dat2  out  32  write data, {16'h0, attr, char}.
- io_bus_dat4  in  32  read data; bits [15:0] valid.
- io_bus_sel  out  1  transaction strobe.
- io_bus_we  out  1  1=write, 0=read.
- io_bus_ack  in  1  slave ack.
- io_cursor_x  out  7  current column.
- io_cursor_y  out  5  current row.
- io_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, async) forces:
  - all bus outputs to 0;
  - cursor to (0,0);
  - state to IDLE;
  - io_in_ready to 0 while reset is asserted.
- Reset mid-transaction drops sel immediately; no completion is required.
- io_in_ready = (state==IDLE) && reset deasserted, combinational from the state register.
- Bus master protocol (all bus outputs registered):
  - Raise sel with addr/we/dat2 stable.
  - Set a seen_low flag on the first cycle that ack==0 while sel is high.
  - Completion is the cycle with sel && ack && seen_low. Capture dat4[15:0] then; drop sel and clear seen_low at that edge.
  - sel stays low for at least 1 cycle between transactions.
  - Nominal transaction is 3 sel cycles + 1 idle cycle. There is no timeout; the block waits indefinitely for ack.
- Character handling on accept (cursor x,y; idx = y*COLS + x, computed in 12 bits):
  - 0x20..0x7E: write {attr, byte} to idx, then x++. If x becomes COLS: x=0, y++.
  - 0x0A (LF): x=0, y++.
  - 0x0D (CR): x=0, no bus access.
  - 0x08 (BS): if x>0, x-- and write {attr, 0x20} at the new idx. If x==0, no action.
  - 0x09 (TAB): x = (x|7)+1, no writes. If the result is >= COLS, behave as LF.
  - 0x0C (FF): clear the whole screen (write {attr, 0x20} to idx 0..COLS*ROWS-1), then cursor (0,0).
  - All other bytes are ignored; they are accepted and the block returns to IDLE the next cycle.
- Scroll triggers whenever y would become ROWS:
  - For i = 0..COLS*(ROWS-1)-1: read idx i+COLS, then write the read value (attr preserved) to idx i.
  - Then write {attr, 0x20} to idx COLS*(ROWS-1) .. COLS*ROWS-1.
  - Final cursor: y=ROWS-1, x as set by the triggering character (0).
- States:
  - IDLE
  - PUTC: one write
  - SCR_RD / SCR_WR: alternating copy
  - FILL: clear range [fill_lo, fill_hi]; shared by scroll-tail and FF
  - BUS_GAP: mandatory idle cycle
- Transitions: a transaction state goes to BUS_GAP on completion, and BUS_GAP goes to the next state. PUTC/BS return to IDLE, or enter SCR_RD if scroll is needed after the cursor update.
- Cursor outputs update at the edge where the operation's last transaction completes. For no-bus characters they update at the accept edge.
- io_attr is latched at accept and used for every write of that operation, including scroll tail fill.

Test Plan:
- Reset release, send 'A' (0x41) with attr 0x07 -> one write: addr 0x000, dat2 0x00000741, we=1; cursor (1,0); ready low until 1 cycle after completion.
- Cursor at (79,2), send 'Z' -> write addr 239 (0xEF); cursor (0,3).
- Cursor (5,4), send BS -> write {attr,0x20} to idx 324; cursor (4,4). Cursor (0,4), send BS -> no sel pulse, cursor unchanged.
- Preload VGA model cell 80 = 0x1E41, cursor (3,29), send LF -> cell 0 reads back 0x1E41; cells 2320..2399 = {attr,0x20}; exactly 2320 reads, 2400 writes; cursor (0,29).
- Send FF -> 2400 writes of {attr,0x20} to idx 0..2399; cursor (0,0). Also: slave ack stretched by 5 extra low cycles -> no extra transactions, data held stable.
- Assert reset during scroll copy -> sel=0 within the same cycle (async); after release, cursor (0,0), ready=1.
